// File: rtl/my_fifo_pkg.sv
// Constants and helpers shared between the distributed-RAM FIFO and its read-side adapter.
package my_fifo_pkg;

  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  // Circular pointer advance; wraps at depth-1 so non-power-of-2 depths work.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/my_fifo_rd_stream.sv
// FIFO read-side adapter: prefetch queue presented as valid/ready, o_valid 1+RD_LAT cycles after rden.
// i_ready only pops the queue; reads are issued from queue room alone, so ready never reaches rden.
module my_fifo_rd_stream
  import my_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 0,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_flush,
  output logic                           o_fifo_rden,
  input  logic [DATA_W-1:0]              i_fifo_rddata,
  input  logic                           i_fifo_empty,
  output logic                           o_valid,
  output logic [DATA_W-1:0]              o_data,
  input  logic                           i_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0] o_count,
  output logic [CNT_W-1:0]               o_beats
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH+1);

  initial begin
    if (RD_LAT != RD_LAT_COMB && RD_LAT != RD_LAT_REG)
      $fatal(1, "my_fifo_rd_stream: RD_LAT must be 0 or 1");
    if (BUF_DEPTH < 2)
      $fatal(1, "my_fifo_rd_stream: BUF_DEPTH must be >= 2");
  end

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wrptr;
  logic [PTR_W-1:0]  r_rdptr;
  logic [OCC_W-1:0]  r_occ;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_beats;

  logic w_room;
  logic w_rden;
  logic w_push;
  logic w_pop;

  // Words already requested count against room, so a landing read always has a slot.
  assign w_room = (int'(r_occ) + int'(r_inflight)) < BUF_DEPTH;
  assign w_rden = !rst && i_en && !i_fifo_empty && !i_flush && w_room;
  assign w_push = (RD_LAT == RD_LAT_COMB) ? w_rden : r_inflight;
  assign w_pop  = (r_occ != '0) && i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrptr    <= '0;
      r_rdptr    <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_beats    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wrptr    <= '0;
      r_rdptr    <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= (RD_LAT == RD_LAT_REG) && w_rden;
      if (w_push) begin
        r_mem[r_wrptr] <= i_fifo_rddata;
        r_wrptr        <= PTR_W'(ptr_inc(int'(r_wrptr), BUF_DEPTH));
      end
      if (w_pop) begin
        r_rdptr <= PTR_W'(ptr_inc(int'(r_rdptr), BUF_DEPTH));
        r_beats <= r_beats + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst)
                   !(w_push && !i_flush && (int'(r_occ) == BUF_DEPTH)))
    else $error("my_fifo_rd_stream: push into full prefetch queue");

  assign o_fifo_rden = w_rden;
  assign o_valid     = (r_occ != '0);
  assign o_data      = r_mem[r_rdptr];
  assign o_count     = r_occ;
  assign o_beats     = r_beats;

endmodule
